// File: rtl/bingo_engine_pkg.sv
// rtl/bingo_engine_pkg.sv - shared state encoding and width helper for the bingo engine
package bingo_engine_pkg;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_REPORT = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // ceil(log2(v)), never below 1 so single-entry counters still have a bit
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bingo_card_store.sv
// rtl/bingo_card_store.sv - card number register file with per-slot mark bits
module bingo_card_store #(
  parameter int TOTAL      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [TOTAL-1:0]      mark_set,
  output logic [TOTAL-1:0]      marks
);

  logic [DATA_WIDTH-1:0] mem [TOTAL];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < TOTAL; i++) mem[i] <= '0;
      marks <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      marks <= marks | mark_set;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bingo_engine.sv
// rtl/bingo_engine.sv - N-player bingo core: card load, draw handshake, sequential scan, hit/winner report
module bingo_engine
  import bingo_engine_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CARD_SIZE   = 8,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              new_game,
  input  logic                              load_valid,
  input  logic [DATA_WIDTH-1:0]             load_data,
  output logic                              load_ready,
  output logic                              cards_full,
  input  logic                              start,
  input  logic                              draw_valid,
  input  logic [DATA_WIDTH-1:0]             draw_number,
  output logic                              draw_ready,
  output logic                              result_valid,
  output logic                              result_dup,
  output logic [NUM_PLAYERS-1:0]            hit_mask,
  output logic [NUM_PLAYERS-1:0]            winner_mask,
  output logic [NUM_PLAYERS*CARD_SIZE-1:0]  marks,
  output logic [DATA_WIDTH-1:0]             last_draw,
  output logic                              game_over
);

  localparam int TOTAL = NUM_PLAYERS * CARD_SIZE;
  localparam int IDX_W = clog2(TOTAL);
  localparam int WR_W  = clog2(TOTAL + 1);
  localparam int PW    = clog2(NUM_PLAYERS);
  localparam int EW    = clog2(CARD_SIZE);
  localparam int HIST  = 2 ** DATA_WIDTH;

  localparam logic [WR_W-1:0]  WR_FULL    = WR_W'(TOTAL);
  localparam logic [IDX_W-1:0] SCAN_LAST  = IDX_W'(TOTAL - 1);
  localparam logic [EW-1:0]    ENTRY_LAST = EW'(CARD_SIZE - 1);

  state_t state, state_nxt;

  logic                   clr;
  logic [WR_W-1:0]        wr_ptr;
  logic [HIST-1:0]        history;
  logic [IDX_W-1:0]       scan_ptr;
  logic [PW-1:0]          player;
  logic [EW-1:0]          entry;
  logic [NUM_PLAYERS-1:0] hit_acc;
  logic [NUM_PLAYERS-1:0] winner_q;
  logic [NUM_PLAYERS-1:0] win_now;
  logic                   dup_q;
  logic                   load_fire;
  logic                   draw_fire;
  logic                   seen;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   match;
  logic                   new_hit;
  logic [TOTAL-1:0]       mark_set;

  assign clr       = rst | new_game;
  assign load_fire = load_valid & load_ready;
  assign draw_fire = draw_valid & draw_ready;
  assign seen      = history[draw_number];

  assign match    = (state == ST_SCAN) && (rd_data == last_draw);
  assign new_hit  = match && !marks[scan_ptr];
  assign mark_set = match ? (TOTAL'(1) << scan_ptr) : '0;

  bingo_card_store #(
    .TOTAL      (TOTAL),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_store (
    .clk      (clk),
    .clr      (clr),
    .wr_en    (load_fire),
    .wr_addr  (wr_ptr[IDX_W-1:0]),
    .wr_data  (load_data),
    .rd_addr  (scan_ptr),
    .rd_data  (rd_data),
    .mark_set (mark_set),
    .marks    (marks)
  );

  // A player wins once every slot on their card is marked; simultaneous completions form a tie.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_win
    assign win_now[p] = &marks[p*CARD_SIZE +: CARD_SIZE];
  end

  always_ff @(posedge clk) begin
    if (clr) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:   if (start && cards_full) state_nxt = ST_PLAY;
      ST_PLAY:   if (draw_fire) state_nxt = seen ? ST_REPORT : ST_SCAN;
      ST_SCAN:   if (scan_ptr == SCAN_LAST) state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = (|win_now) ? ST_OVER : ST_PLAY;
      ST_OVER:   state_nxt = ST_OVER;
      default:   state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr    <= '0;
      history   <= '0;
      last_draw <= '0;
      scan_ptr  <= '0;
      player    <= '0;
      entry     <= '0;
      hit_acc   <= '0;
      dup_q     <= 1'b0;
      winner_q  <= '0;
    end else begin
      if (load_fire) wr_ptr <= wr_ptr + WR_W'(1);

      if (draw_fire) begin
        last_draw <= draw_number;
        dup_q     <= seen;
        hit_acc   <= '0;
        scan_ptr  <= '0;
        player    <= '0;
        entry     <= '0;
        if (!seen) history[draw_number] <= 1'b1;
      end

      // Player index tracks the slot via a (player, entry) counter pair instead of a divide.
      if (state == ST_SCAN) begin
        if (new_hit) hit_acc[player] <= 1'b1;
        if (scan_ptr != SCAN_LAST) begin
          scan_ptr <= scan_ptr + IDX_W'(1);
          if (entry == ENTRY_LAST) begin
            entry  <= '0;
            player <= player + PW'(1);
          end else begin
            entry <= entry + EW'(1);
          end
        end
      end

      if (state == ST_REPORT) winner_q <= win_now;
    end
  end

  assign cards_full   = (wr_ptr == WR_FULL);
  assign load_ready   = (state == ST_LOAD) && !cards_full;
  assign draw_ready   = (state == ST_PLAY);
  assign result_valid = (state == ST_REPORT);
  assign result_dup   = (state == ST_REPORT) && dup_q;
  assign hit_mask     = (state == ST_REPORT) ? hit_acc : '0;
  assign winner_mask  = (state == ST_REPORT) ? win_now : winner_q;
  assign game_over    = (state == ST_OVER);

endmodule
